// File: rtl/recovery_sequencer_pkg.sv
// Shared pipeline recovery types: refetch kinds, pipeline phases, request record and helpers.
package recovery_sequencer_pkg;

    localparam int RECOVERY_REQ_NUM        = 3;
    localparam int RECOVERY_AL_INDEX_WIDTH = 6;
    localparam int RECOVERY_PC_WIDTH       = 32;

    typedef enum logic [2:0] {
        REFETCH_THIS_PC               = 3'd0,
        REFETCH_NEXT_PC               = 3'd1,
        REFETCH_BRANCH_TARGET         = 3'd2,
        REFETCH_STORE_NEXT_PC         = 3'd3,
        REFETCH_NEXT_PC_TO_CSR_TARGET = 3'd4,
        REFETCH_THIS_PC_TO_CSR_TARGET = 3'd5
    } RefetchType;

    typedef enum logic [1:0] {
        PHASE_COMMIT    = 2'd0,
        PHASE_RECOVER_0 = 2'd1,
        PHASE_RECOVER_1 = 2'd2
    } PipelinePhase;

    typedef struct packed {
        logic                               valid;
        RefetchType                         refetchType;
        logic [RECOVERY_AL_INDEX_WIDTH-1:0] alPtr;
        logic [RECOVERY_PC_WIDTH-1:0]       pc;
        logic [RECOVERY_PC_WIDTH-1:0]       brTarget;
    } RefetchRequest;

    function automatic logic is_legal_type(input logic [2:0] t);
        return (t <= 3'd5);
    endfunction

    function automatic logic is_inclusive(input RefetchType t);
        return (t == REFETCH_THIS_PC) || (t == REFETCH_THIS_PC_TO_CSR_TARGET);
    endfunction

    function automatic logic [RECOVERY_PC_WIDTH-1:0] target_pc(
        input RefetchRequest                  r,
        input logic [RECOVERY_PC_WIDTH-1:0]   csr
    );
        logic [RECOVERY_PC_WIDTH-1:0] t;
        case (r.refetchType)
            REFETCH_THIS_PC:               t = r.pc;
            REFETCH_NEXT_PC:               t = r.pc + 32'd4;
            REFETCH_STORE_NEXT_PC:         t = r.pc + 32'd4;
            REFETCH_BRANCH_TARGET:         t = r.brTarget;
            REFETCH_NEXT_PC_TO_CSR_TARGET: t = csr;
            REFETCH_THIS_PC_TO_CSR_TARGET: t = csr;
            default:                       t = r.pc;
        endcase
        return t;
    endfunction

    function automatic logic [31:0] count_ones(input logic [RECOVERY_REQ_NUM-1:0] v);
        logic [31:0] n;
        n = 32'd0;
        for (int i = 0; i < RECOVERY_REQ_NUM; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/refetch_oldest_picker.sv
// Picks the oldest valid entry by active-list age relative to head; ties go to the lowest index.
module refetch_oldest_picker #(
    parameter int NUM   = 3,
    parameter int AL_W  = 6,
    parameter int IDX_W = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic [NUM-1:0]           valid,
    input  logic [NUM-1:0][AL_W-1:0] al_ptr,
    input  logic [AL_W-1:0]          head,
    output logic                     pick_valid,
    output logic [IDX_W-1:0]         pick_idx
);

    logic [AL_W-1:0] age_s;
    logic [AL_W-1:0] best_age_s;

    // linear scan; strict less-than keeps the lowest index on equal age
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        best_age_s = '0;
        age_s      = '0;
        for (int i = 0; i < NUM; i++) begin
            age_s = al_ptr[i] - head;
            if (valid[i] && (!pick_valid || (age_s < best_age_s))) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(i);
                best_age_s = age_s;
            end else begin
                best_age_s = best_age_s;
            end
        end
    end

endmodule

// File: rtl/recovery_sequencer.sv
// Selects the oldest refetch request and sequences COMMIT -> RECOVER_0 -> RECOVER_1 recovery.
// Optional perfCount port and counters are built when RSD_RECOVERY_PERF_COUNTER_EN is defined.
module recovery_sequencer
    import recovery_sequencer_pkg::*;
#(
    parameter int REQ_NUM        = RECOVERY_REQ_NUM,
    parameter int AL_INDEX_WIDTH = RECOVERY_AL_INDEX_WIDTH,
    parameter int PC_WIDTH       = RECOVERY_PC_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    rstN,
    input  logic [REQ_NUM-1:0]                      reqValid,
    input  logic [REQ_NUM-1:0][2:0]                 reqType,
    input  logic [REQ_NUM-1:0][AL_INDEX_WIDTH-1:0]  reqAlPtr,
    input  logic [REQ_NUM-1:0][PC_WIDTH-1:0]        reqPC,
    input  logic [REQ_NUM-1:0][PC_WIDTH-1:0]        reqBrTarget,
    input  logic [PC_WIDTH-1:0]                     csrTarget,
    input  logic [AL_INDEX_WIDTH-1:0]               alHeadPtr,
    input  logic                                    walkDone,
    output logic [1:0]                              phase,
    output logic                                    refetchValid,
    output logic [PC_WIDTH-1:0]                     refetchPC,
    output logic [AL_INDEX_WIDTH-1:0]               flushPtr,
    output logic                                    flushInclusive,
    output logic                                    busy
`ifdef RSD_RECOVERY_PERF_COUNTER_EN
    ,
    output logic [6:0][31:0]                        perfCount
`endif
);

    localparam int SEL_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    PipelinePhase                            state_r, next_state_s;
    logic [REQ_NUM-1:0][AL_INDEX_WIDTH-1:0]  age_s;
    logic [AL_INDEX_WIDTH-1:0]               cur_age_s;
    logic [REQ_NUM-1:0]                      legal_s, older_s, cand_s, drop_s;
    logic                                    in_recovery_s;
    logic                                    in_valid_s;
    logic [SEL_W-1:0]                        in_idx_s;
    RefetchRequest                           in_req_s, pend_r, pend_next_s, merged_req_s;
    logic [PC_WIDTH-1:0]                     in_target_s, pend_target_r, pend_target_next_s;
    logic [PC_WIDTH-1:0]                     merged_target_s, launch_target_s;
    logic                                    merge_valid_s;
    logic [0:0]                              merge_idx_s;
    logic                                    launch_s;
    RefetchType                              launch_type_s;
    logic [AL_INDEX_WIDTH-1:0]               launch_ptr_s;

    assign phase = state_r;

    // during recovery only requests strictly older than the in-flight one survive
    always_comb begin
        cur_age_s     = flushPtr - alHeadPtr;
        in_recovery_s = (state_r != PHASE_COMMIT);
        for (int i = 0; i < REQ_NUM; i++) begin
            age_s[i]   = reqAlPtr[i] - alHeadPtr;
            legal_s[i] = reqValid[i] && is_legal_type(reqType[i]);
            older_s[i] = legal_s[i] && (age_s[i] < cur_age_s);
        end
        if (in_recovery_s) begin
            cand_s = older_s;
            drop_s = legal_s & ~older_s;
        end else begin
            cand_s = legal_s;
            drop_s = '0;
        end
    end

    refetch_oldest_picker #(.NUM(REQ_NUM), .AL_W(AL_INDEX_WIDTH)) u_in_picker (
        .valid      (cand_s),
        .al_ptr     (reqAlPtr),
        .head       (alHeadPtr),
        .pick_valid (in_valid_s),
        .pick_idx   (in_idx_s)
    );

    // gather the winning port into a request record and resolve its target now
    always_comb begin
        in_req_s.valid       = in_valid_s;
        in_req_s.refetchType = RefetchType'(reqType[in_idx_s]);
        in_req_s.alPtr       = reqAlPtr[in_idx_s];
        in_req_s.pc          = reqPC[in_idx_s];
        in_req_s.brTarget    = reqBrTarget[in_idx_s];
        in_target_s          = target_pc(in_req_s, csrTarget);
    end

    refetch_oldest_picker #(.NUM(2), .AL_W(AL_INDEX_WIDTH)) u_merge_picker (
        .valid      ({in_valid_s & in_recovery_s, pend_r.valid}),
        .al_ptr     ({in_req_s.alPtr, pend_r.alPtr}),
        .head       (alHeadPtr),
        .pick_valid (merge_valid_s),
        .pick_idx   (merge_idx_s)
    );

    // older of pending and surviving incoming request
    always_comb begin
        if (merge_idx_s == 1'b1) begin
            merged_req_s    = in_req_s;
            merged_target_s = in_target_s;
        end else begin
            merged_req_s    = pend_r;
            merged_target_s = pend_target_r;
        end
    end

    // phase state register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_r <= PHASE_COMMIT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // next-phase logic
    always_comb begin
        case (state_r)
            PHASE_COMMIT: begin
                if (in_valid_s) next_state_s = PHASE_RECOVER_0;
                else            next_state_s = PHASE_COMMIT;
            end
            PHASE_RECOVER_0: next_state_s = PHASE_RECOVER_1;
            PHASE_RECOVER_1: begin
                if (walkDone && merge_valid_s) next_state_s = PHASE_RECOVER_0;
                else if (walkDone)             next_state_s = PHASE_COMMIT;
                else                           next_state_s = PHASE_RECOVER_1;
            end
            default: next_state_s = PHASE_COMMIT;
        endcase
    end

    // launch decision and pending-register update
    always_comb begin
        launch_s           = 1'b0;
        launch_type_s      = in_req_s.refetchType;
        launch_ptr_s       = in_req_s.alPtr;
        launch_target_s    = in_target_s;
        pend_next_s        = pend_r;
        pend_target_next_s = pend_target_r;
        case (state_r)
            PHASE_COMMIT: begin
                if (in_valid_s) launch_s = 1'b1;
                else            launch_s = 1'b0;
            end
            PHASE_RECOVER_0: begin
                if (merge_valid_s) begin
                    pend_next_s        = merged_req_s;
                    pend_target_next_s = merged_target_s;
                end else begin
                    pend_next_s        = pend_r;
                end
            end
            PHASE_RECOVER_1: begin
                if (walkDone && merge_valid_s) begin
                    // the loser is younger than the new recovery and gets flushed with it
                    launch_s          = 1'b1;
                    launch_type_s     = merged_req_s.refetchType;
                    launch_ptr_s      = merged_req_s.alPtr;
                    launch_target_s   = merged_target_s;
                    pend_next_s.valid = 1'b0;
                end else if (merge_valid_s) begin
                    pend_next_s        = merged_req_s;
                    pend_target_next_s = merged_target_s;
                end else begin
                    pend_next_s        = pend_r;
                end
            end
            default: launch_s = 1'b0;
        endcase
    end

    // registered outputs and pending request
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            refetchValid   <= 1'b0;
            refetchPC      <= '0;
            flushPtr       <= '0;
            flushInclusive <= 1'b0;
            busy           <= 1'b0;
            pend_r         <= '0;
            pend_target_r  <= '0;
        end else begin
            refetchValid  <= launch_s;
            busy          <= (next_state_s != PHASE_COMMIT) || pend_next_s.valid;
            pend_r        <= pend_next_s;
            pend_target_r <= pend_target_next_s;
            if (launch_s) begin
                refetchPC      <= launch_target_s;
                flushPtr       <= launch_ptr_s;
                flushInclusive <= is_inclusive(launch_type_s);
            end else begin
                refetchPC      <= refetchPC;
                flushPtr       <= flushPtr;
                flushInclusive <= flushInclusive;
            end
        end
    end

`ifdef RSD_RECOVERY_PERF_COUNTER_EN
    RefetchType       last_type_r;
    logic [6:0][31:0] perf_r;
    logic [32:0]      drop_sum_s;

    assign perfCount = perf_r;

    // saturating sum for the drop counter
    always_comb begin
        drop_sum_s = {1'b0, perf_r[6]} + {1'b0, count_ones(drop_s)};
    end

    // type of the recovery whose pulse is on refetchValid
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            last_type_r <= REFETCH_THIS_PC;
        end else if (launch_s) begin
            last_type_r <= launch_type_s;
        end else begin
            last_type_r <= last_type_r;
        end
    end

    // per-type recovery counters and drop counter
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            perf_r <= '0;
        end else begin
            for (int k = 0; k < 6; k++) begin
                if (refetchValid && (last_type_r == RefetchType'(3'(k))) && (perf_r[k] != 32'hFFFF_FFFF)) begin
                    perf_r[k] <= perf_r[k] + 32'd1;
                end else begin
                    perf_r[k] <= perf_r[k];
                end
            end
            if (drop_sum_s[32]) perf_r[6] <= 32'hFFFF_FFFF;
            else                perf_r[6] <= drop_sum_s[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_recovery_sequencer.sv
// Directed bench for recovery_sequencer; expected redirects are queued at stimulus time and checked on each pulse.
module tb_recovery_sequencer;

    logic                  clk;
    logic                  rstN;
    logic [2:0]            reqValid;
    logic [2:0][2:0]       reqType;
    logic [2:0][5:0]       reqAlPtr;
    logic [2:0][31:0]      reqPC;
    logic [2:0][31:0]      reqBrTarget;
    logic [31:0]           csrTarget;
    logic [5:0]            alHeadPtr;
    logic                  walkDone;
    logic [1:0]            phase;
    logic                  refetchValid;
    logic [31:0]           refetchPC;
    logic [5:0]            flushPtr;
    logic                  flushInclusive;
    logic                  busy;
`ifdef RSD_RECOVERY_PERF_COUNTER_EN
    logic [6:0][31:0]      perfCount;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [5:0]  ptr;
        logic        incl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    recovery_sequencer dut (
        .clk            (clk),
        .rstN           (rstN),
        .reqValid       (reqValid),
        .reqType        (reqType),
        .reqAlPtr       (reqAlPtr),
        .reqPC          (reqPC),
        .reqBrTarget    (reqBrTarget),
        .csrTarget      (csrTarget),
        .alHeadPtr      (alHeadPtr),
        .walkDone       (walkDone),
        .phase          (phase),
        .refetchValid   (refetchValid),
        .refetchPC      (refetchPC),
        .flushPtr       (flushPtr),
        .flushInclusive (flushInclusive),
        .busy           (busy)
`ifdef RSD_RECOVERY_PERF_COUNTER_EN
        ,
        .perfCount      (perfCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_target(input int t, input logic [31:0] pc,
                                                 input logic [31:0] br, input logic [31:0] csr);
        case (t)
            0:       return pc;
            1, 3:    return pc + 32'd4;
            2:       return br;
            4, 5:    return csr;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        reqValid = 3'b000;
    endtask

    task automatic drive(input int port, input int t, input int ptr, input logic [31:0] pc, input logic [31:0] br);
        reqValid[port]    = 1'b1;
        reqType[port]     = 3'(t);
        reqAlPtr[port]    = 6'(ptr);
        reqPC[port]       = pc;
        reqBrTarget[port] = br;
    endtask

    task automatic push_exp(input int t, input int ptr, input logic [31:0] pc, input logic [31:0] br, input logic [31:0] csr);
        exp_t e;
        e.pc   = model_target(t, pc, br, csr);
        e.ptr  = 6'(ptr);
        e.incl = (t == 0) || (t == 5);
        exp_q.push_back(e);
    endtask

    task automatic check_pulse(input string tag);
        exp_t e;
        check({tag, " refetchValid"}, {63'd0, refetchValid}, 64'd1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard: observed pulse expected none queued", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, " refetchPC"}, {32'd0, refetchPC}, {32'd0, e.pc});
            check({tag, " flushPtr"}, {58'd0, flushPtr}, {58'd0, e.ptr});
            check({tag, " flushInclusive"}, {63'd0, flushInclusive}, {63'd0, e.incl});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " phase"}, {62'd0, phase}, 64'd0);
        check({tag, " refetchValid"}, {63'd0, refetchValid}, 64'd0);
        check({tag, " refetchPC"}, {32'd0, refetchPC}, 64'd0);
        check({tag, " flushPtr"}, {58'd0, flushPtr}, 64'd0);
        check({tag, " flushInclusive"}, {63'd0, flushInclusive}, 64'd0);
        check({tag, " busy"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic finish_walk();
        walkDone = 1'b1;
        tick();
        walkDone = 1'b0;
    endtask

    initial begin
        rstN = 1'b0; reqValid = 3'b000; reqType = '0; reqAlPtr = '0; reqPC = '0;
        reqBrTarget = '0; csrTarget = 32'd0; alHeadPtr = 6'd0; walkDone = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        rstN = 1'b1;
        tick();

        // single branch-target recovery
        alHeadPtr = 6'd2;
        drive(0, 2, 5, 32'h40, 32'h1000);
        push_exp(2, 5, 32'h40, 32'h1000, csrTarget);
        tick(); clear_reqs();
        check("t1 phase r0", {62'd0, phase}, 64'd1);
        check_pulse("t1");
        check("t1 busy", {63'd0, busy}, 64'd1);
        tick();
        check("t1 phase r1", {62'd0, phase}, 64'd2);
        check("t1 pulse ends", {63'd0, refetchValid}, 64'd0);
        check("t1 pc held", {32'd0, refetchPC}, 64'h1000);
        tick(); tick();
        check("t1 still r1", {62'd0, phase}, 64'd2);
        finish_walk();
        check("t1 commit", {62'd0, phase}, 64'd0);
        check("t1 idle", {63'd0, busy}, 64'd0);

        // wrap-around age: port 2 (age 3) beats port 0 (age 5); walkDone in R0 ignored
        alHeadPtr = 6'd62;
        drive(0, 1, 3, 32'h100, 32'h0);
        drive(2, 0, 1, 32'h200, 32'h0);
        push_exp(0, 1, 32'h200, 32'h0, csrTarget);
        tick(); clear_reqs();
        check_pulse("t2");
        walkDone = 1'b1;
        tick();
        check("t2 r0 ignores walkDone", {62'd0, phase}, 64'd2);
        tick();
        walkDone = 1'b0;
        check("t2 commit", {62'd0, phase}, 64'd0);

        // drop younger, pend older, chain straight to RECOVER_0
        alHeadPtr = 6'd0;
        drive(0, 2, 10, 32'h0, 32'h500);
        push_exp(2, 10, 32'h0, 32'h500, csrTarget);
        tick(); clear_reqs();
        check_pulse("t3 first");
        tick();
        drive(1, 1, 12, 32'h400, 32'h0);
        tick(); clear_reqs();
        check("t3 drop phase", {62'd0, phase}, 64'd2);
        check("t3 drop no pulse", {63'd0, refetchValid}, 64'd0);
        check("t3 drop flushPtr", {58'd0, flushPtr}, 64'd10);
        drive(2, 1, 4, 32'h300, 32'h0);
        push_exp(1, 4, 32'h300, 32'h0, csrTarget);
        tick(); clear_reqs();
        check("t3 pending busy", {63'd0, busy}, 64'd1);
        finish_walk();
        check("t3 chained r0", {62'd0, phase}, 64'd1);
        check_pulse("t3 pending");
        tick();
        check("t3 r1", {62'd0, phase}, 64'd2);
        finish_walk();
        check("t3 commit", {62'd0, phase}, 64'd0);
        check("t3 no extra pulse", {63'd0, refetchValid}, 64'd0);
        check("t3 idle", {63'd0, busy}, 64'd0);

        // CSR target with an illegal older request alongside
        csrTarget = 32'h80;
        drive(0, 5, 7, 32'h600, 32'h0);
        drive(1, 7, 2, 32'h700, 32'h0);
        push_exp(5, 7, 32'h600, 32'h0, 32'h80);
        tick(); clear_reqs();
        csrTarget = 32'h90;
        check_pulse("t4 csr");
        tick();
        finish_walk();

        // equal age tie goes to port 0; PC+4 wraps
        drive(0, 3, 20, 32'hFFFF_FFFC, 32'h0);
        drive(1, 2, 20, 32'h0, 32'h999);
        push_exp(3, 20, 32'hFFFF_FFFC, 32'h0, csrTarget);
        tick(); clear_reqs();
        check_pulse("t5 tie");
        tick();
        finish_walk();

        // asynchronous reset mid-recovery with a pending request
        drive(0, 2, 10, 32'h0, 32'h500);
        push_exp(2, 10, 32'h0, 32'h500, csrTarget);
        tick(); clear_reqs();
        check_pulse("t6 first");
        tick();
        drive(2, 1, 4, 32'h300, 32'h0);
        tick(); clear_reqs();
        check("t6 busy before reset", {63'd0, busy}, 64'd1);
        rstN = 1'b0;
        #1;
        check_reset_outputs("t6 async reset");
        @(negedge clk);
        rstN = 1'b1;
        walkDone = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6 stays idle phase", {62'd0, phase}, 64'd0);
            check("t6 no pulse", {63'd0, refetchValid}, 64'd0);
            check("t6 not busy", {63'd0, busy}, 64'd0);
        end
        walkDone = 1'b0;

`ifdef RSD_RECOVERY_PERF_COUNTER_EN
        // counters: three branch-target recoveries, one drop
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        tick();
        alHeadPtr = 6'd0;
        for (int r = 0; r < 3; r++) begin
            drive(0, 2, 10 + 10 * r, 32'h0, 32'h1000 + 32'(r));
            push_exp(2, 10 + 10 * r, 32'h0, 32'h1000 + 32'(r), csrTarget);
            tick(); clear_reqs();
            check_pulse("perf run");
            tick();
            if (r == 0) begin
                drive(1, 1, 15, 32'h400, 32'h0);
                tick(); clear_reqs();
            end
            finish_walk();
        end
        tick();
        for (int k = 0; k < 7; k++) begin
            check($sformatf("perf counter %0d", k), {32'd0, perfCount[k]},
                  (k == 2) ? 64'd3 : ((k == 6) ? 64'd1 : 64'd0));
        end
`endif

        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/recovery_sequencer.md
# recovery_sequencer

Collects refetch requests from the back-end register-write stages (integer, complex-integer, memory), picks the oldest by active-list age, and sequences the pipeline recovery phases. Drives the refetch PC, the flush boundary, and the current recovery phase to the fetch unit, rename logic and active list. Sits directly downstream of the register-write stages and upstream of fetch and rename recovery.

## Interface
- `REQ_NUM`, 3: number of refetch request ports (0 = int, 1 = complex, 2 = memory).
- `AL_INDEX_WIDTH`, 6: active-list index width (64 entries).
- `PC_WIDTH`, 32: PC width.
- `clk`  in  1: clock.
- `rstN`  in  1: reset, asynchronous assert, active-low.
- `reqValid`  in  REQ_NUM: refetch request per port.
- `reqType`  in  REQ_NUM×3: `RefetchType` per port.
- `reqAlPtr`  in  REQ_NUM×AL_INDEX_WIDTH: active-list pointer of the requesting op.
- `reqPC`  in  REQ_NUM×PC_WIDTH: PC of the requesting op.
- `reqBrTarget`  in  REQ_NUM×PC_WIDTH: correct branch target (BRANCH_TARGET only).
- `csrTarget`  in  PC_WIDTH: trap vector from CSR unit.
- `alHeadPtr`  in  AL_INDEX_WIDTH: active-list head (oldest op).
- `walkDone`  in  1: rename/active-list rollback finished.
- `phase`  out  2: `PipelinePhase`.
- `refetchValid`  out  1: one-cycle pulse; fetch redirects to `refetchPC`.
- `refetchPC`  out  PC_WIDTH: redirect target.
- `flushPtr`  out  AL_INDEX_WIDTH: active-list pointer of the op that caused the recovery.
- `flushInclusive`  out  1: flush includes the causing op itself.
- `busy`  out  1: phase != PHASE_COMMIT or a pending request exists.

## Operation
- Age of a request = (`reqAlPtr` − `alHeadPtr`) mod 2^AL_INDEX_WIDTH. Smaller age is older. On equal age the lowest port index wins.
- Target PC per type:
  - THIS_PC → `reqPC`.
  - NEXT_PC and STORE_NEXT_PC → `reqPC`+4 (mod 2^PC_WIDTH).
  - BRANCH_TARGET → `reqBrTarget`.
  - NEXT_PC_TO_CSR_TARGET and THIS_PC_TO_CSR_TARGET → `csrTarget`, sampled in the cycle the request is accepted.
  - The 3-bit values 6 and 7 are illegal: the request is ignored.
- `flushInclusive` = 1 for THIS_PC and THIS_PC_TO_CSR_TARGET, else 0.
- FSM over `PipelinePhase`:
  - COMMIT: if any legal request arrives, latch the oldest and go to RECOVER_0.
  - RECOVER_0: lasts exactly one cycle, then goes to RECOVER_1.
  - RECOVER_1: stays until `walkDone`=1, then goes to COMMIT.
- Requests during RECOVER_0/RECOVER_1:
  - A request younger than or equal in age to the in-progress recovery is dropped, because that op is being flushed.
  - A strictly older request goes into a single pending register. If the register is already occupied, the older of the two is kept.
- Leaving RECOVER_1 with pending valid goes straight to RECOVER_0 with the pending request; COMMIT is skipped.
- Age for both drop and pending comparison uses the current `alHeadPtr`.

## Timing
- Reset values:
  - `phase`=PHASE_COMMIT.
  - `refetchValid`=0, `refetchPC`=0, `flushPtr`=0, `flushInclusive`=0, `busy`=0.
  - Pending register invalid.
- A request sampled at edge t gives, from t+1:
  - `phase`=RECOVER_0.
  - `refetchValid`=1 for that single cycle.
  - `refetchPC`, `flushPtr` and `flushInclusive` registered, and held until the next accepted recovery.
- `phase`=RECOVER_1 from t+2. If `walkDone` is sampled at edge u, then `phase`=COMMIT at u+1.
- Minimum recovery is 2 cycles; back-to-back recoveries are possible through pending.
- `walkDone` during COMMIT or RECOVER_0 is ignored.
- A request in the same cycle as `walkDone` in RECOVER_1 is handled as a RECOVER_1 request: it is dropped or made pending.
- Reset asserted mid-recovery: everything returns immediately (asynchronously) to reset values, and pending is lost.

## Configuration
- `RSD_RECOVERY_PERF_COUNTER_EN` defined:
  - Six 32-bit saturating counters, one per RefetchType, increment on each `refetchValid` pulse.
  - A seventh counter counts dropped requests.
  - All counters are exposed on the `perfCount` output (7×32). Reset to 0.
- Undefined: no counters and no `perfCount` port. Behaviour is otherwise identical.

## Structure
- Shared package (PipelineTypes): `RefetchType` and `PipelinePhase` (already present), plus a new `RefetchRequest` struct (valid, type, alPtr, pc, brTarget) and `RECOVERY_REQ_NUM`.
- One sub-module: `refetch_oldest_picker`. Combinational age compare plus select over REQ_NUM requests; it is reused for the pending-versus-incoming comparison.

## Test plan
- Port 0 BRANCH_TARGET, alPtr=5, head=2, brTarget=0x1000 → next cycle: RECOVER_0, `refetchValid`=1, `refetchPC`=0x1000, `flushPtr`=5, `flushInclusive`=0; RECOVER_1 after that. `walkDone` 3 cycles later → COMMIT.
- Same cycle: port 0 alPtr=3 and port 2 THIS_PC alPtr=1 pc=0x200, head=62 → port 2 wins, `refetchPC`=0x200, `flushInclusive`=1 (wrap-around age 3 vs 5).
- During RECOVER_1 for alPtr=10 (head=0): port 1 NEXT_PC alPtr=12 → dropped. Port 2 alPtr=4 pc=0x300 → pending. On `walkDone` → RECOVER_0 the next cycle with `refetchPC`=0x304, `flushPtr`=4.
- THIS_PC_TO_CSR_TARGET with `csrTarget`=0x80 → `refetchPC`=0x80 and `flushInclusive`=1. An illegal type 7 on another port in the same cycle is ignored.
- Reset asserted during RECOVER_1 with pending valid → all outputs return to reset values. After release, `busy`=0 and no recovery fires.
- With the macro defined: three BRANCH_TARGET recoveries and one drop → branch-target counter = 3, drop counter = 1, all others 0.
